// File: rtl/program_loader_if.sv
// Host load channel and instruction-memory write port of the program loader.
interface program_loader_if #(
  parameter int ADDR_W = 5
);
  logic              load_valid;
  logic [31:0]       load_data;
  logic              load_last;
  logic              load_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output load_valid, load_data, load_last,
    input  load_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  load_valid, load_data, load_last,
    output load_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Streams host words into instruction memory, then holds the CPU in reset for
// RST_CYCLES before release. Define PROGRAM_LOADER_CHECKSUM_EN for the XOR checksum.
module program_loader #(
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 5,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              Reset_n,
  program_loader_if.slave   bus,
  input  logic              start,
  input  logic              abort,
  output logic              cpu_reset,
  output logic              cpu_load,
  output logic              running,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_t;

  localparam int                HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W:0]   FULL      = (ADDR_W+1)'(DEPTH);

  state_t            state, next_state;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              loading, ready, xfer;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  assign loading        = (state == S_IDLE) || (state == S_LOAD);
  assign ready          = loading && (word_count != FULL);
  assign xfer           = bus.load_valid && ready;
  assign bus.load_ready = ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= next_state;
      hold_cnt <= hold_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    hold_next  = hold_cnt;
    unique case (state)
      S_IDLE, S_LOAD: begin
        hold_next = '0;
        if (xfer)
          next_state = bus.load_last ? S_HOLD : S_LOAD;
        else if (start && (word_count != '0))
          next_state = S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) next_state = S_RUN;
        else                       hold_next  = hold_cnt + HOLD_W'(1);
      end
      S_RUN: ;
    endcase
    if (abort) begin
      next_state = S_IDLE;
      hold_next  = '0;
    end
  end

  // CPU controls are registered from next_state so they change with the state itself.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      cpu_reset  <= 1'b1;
      cpu_load   <= 1'b0;
      running    <= 1'b0;
    end else begin
      we_q      <= 1'b0;
      cpu_load  <= (next_state == S_IDLE) || (next_state == S_LOAD);
      cpu_reset <= (next_state != S_RUN);
      running   <= (next_state == S_RUN);
      if (abort) begin
        word_count <= '0;
        overflow   <= 1'b0;
      end else begin
        if (xfer) begin
          we_q       <= 1'b1;
          addr_q     <= word_count[ADDR_W-1:0];
          wdata_q    <= bus.load_data;
          word_count <= word_count + (ADDR_W+1)'(1);
        end
        if ((state == S_LOAD) && (word_count == FULL) && bus.load_valid)
          overflow <= 1'b1;
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)   csum_q <= '0;
    else if (abort) csum_q <= '0;
    else if (xfer)  csum_q <= csum_q ^ bus.load_data;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized
// load sessions against a word-level reference model and a write scoreboard.
module tb_program_loader;
  localparam int DEPTH      = 32;
  localparam int ADDR_W     = 5;
  localparam int RST_CYCLES = 2;

  logic              clk = 1'b0;
  logic              Reset_n;
  logic              start, abort;
  logic              cpu_reset, cpu_load, running, overflow;
  logic [ADDR_W:0]   word_count;
  logic [31:0]       checksum;

  program_loader_if #(.ADDR_W(ADDR_W)) bus();

  program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk        (clk),
    .Reset_n    (Reset_n),
    .bus        (bus),
    .start      (start),
    .abort      (abort),
    .cpu_reset  (cpu_reset),
    .cpu_load   (cpu_load),
    .running    (running),
    .word_count (word_count),
    .overflow   (overflow),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: words accepted so far, whether the loader still takes words.
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          m_count;
  bit          m_loading;
  bit          m_ovf;
  logic [31:0] m_csum;
  int          wr_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_csum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    return m_csum;
`else
    return 32'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write scoreboard: each imem_we pulse must match the oldest accepted word.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      int          a;
      logic [31:0] d;
      wr_seen++;
      check("write_expected", 64'(exp_addr.size() > 0), 64'(1));
      if (exp_addr.size() > 0) begin
        a = exp_addr.pop_front();
        d = exp_data.pop_front();
        check("imem_addr", 64'(bus.imem_addr), 64'(a));
        check("imem_wdata", 64'(bus.imem_wdata), 64'(d));
      end
    end
  end

  task automatic model_clear();
    exp_addr.delete();
    exp_data.delete();
    m_count   = 0;
    m_loading = 1'b1;
    m_ovf     = 1'b0;
    m_csum    = '0;
    wr_seen   = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},       64'(bus.imem_we), 64'(0));
    check({tag, "_addr"},     64'(bus.imem_addr), 64'(0));
    check({tag, "_wdata"},    64'(bus.imem_wdata), 64'(0));
    check({tag, "_count"},    64'(word_count), 64'(0));
    check({tag, "_ovf"},      64'(overflow), 64'(0));
    check({tag, "_cpu_rst"},  64'(cpu_reset), 64'(1));
    check({tag, "_cpu_load"}, 64'(cpu_load), 64'(0));
    check({tag, "_running"},  64'(running), 64'(0));
    check({tag, "_csum"},     64'(checksum), 64'(0));
  endtask

  task automatic do_reset();
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    Reset_n        = 1'b0;
    #1;
    check_reset_values("rst");
    repeat (2) tick();
    model_clear();
    Reset_n = 1'b1;
    tick();
    check("rst_release_cpu_load", 64'(cpu_load), 64'(1));
  endtask

  // One clock of stimulus; the model decides what the loader should do with it.
  task automatic step(input bit v, input logic [31:0] d, input bit l, input bit st, input bit ab);
    bit rdy;
    rdy = m_loading && (m_count < DEPTH);
    bus.load_valid = v;
    bus.load_data  = d;
    bus.load_last  = l;
    start          = st;
    abort          = ab;
    check("load_ready", 64'(bus.load_ready), 64'(rdy));
    if (ab) begin
      m_loading = 1'b1;
      m_count   = 0;
      m_ovf     = 1'b0;
      m_csum    = '0;
    end else begin
      if (v && m_loading && (m_count == DEPTH)) m_ovf = 1'b1;
      if (v && rdy) begin
        exp_addr.push_back(m_count);
        exp_data.push_back(d);
        m_count++;
        m_csum ^= d;
        if (l) m_loading = 1'b0;
      end else if (st && m_loading && (m_count > 0)) begin
        m_loading = 1'b0;
      end
    end
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    check("word_count", 64'(word_count), 64'(m_count));
    check("overflow",   64'(overflow), 64'(m_ovf));
    check("checksum",   64'(checksum), 64'(exp_csum()));
    check("cpu_load",   64'(cpu_load), 64'(m_loading));
  endtask

  // Called right after the cycle that ends loading; counts cycles until release.
  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (running !== 1'b1 && n < 20) begin
      check("hold_cpu_reset", 64'(cpu_reset), 64'(1));
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(RST_CYCLES));
    check("run_cpu_reset", 64'(cpu_reset), 64'(0));
    check("run_cpu_load",  64'(cpu_load), 64'(0));
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n        = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    model_clear();
    #2;

    // Eleven-word program, last flagged on the eleventh.
    do_reset();
    for (int i = 0; i < 11; i++)
      step(1'b1, (i == 0) ? 32'h2001_01A7 : $urandom, i == 10, 1'b0, 1'b0);
    check("p11_count", 64'(word_count), 64'(11));
    wait_run("p11_hold_len");
    check("p11_writes", 64'(wr_seen), 64'(11));

    // Thirty-three words into a 32-word memory, then start.
    do_reset();
    for (int i = 0; i < 33; i++)
      step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    check("full_ready", 64'(bus.load_ready), 64'(0));
    check("full_writes", 64'(wr_seen), 64'(DEPTH));
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    wait_run("full_hold_len");
    step(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    check("run_ignores", 64'(running), 64'(1));

    // Start with nothing loaded is ignored.
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    check("empty_start_cpu_reset", 64'(cpu_reset), 64'(1));
    check("empty_start_running", 64'(running), 64'(0));
    check("empty_start_ready", 64'(bus.load_ready), 64'(1));

    // Start colliding with a transfer is ignored; abort with start in RUN wins.
    do_reset();
    step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    wait_run("abort_hold_len");
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("abort_cpu_reset", 64'(cpu_reset), 64'(1));
    check("abort_running", 64'(running), 64'(0));

    // Abort on a transfer cycle cancels that write.
    do_reset();
    step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    check("abort_xfer_writes", 64'(wr_seen), 64'(1));

    // Reset asserted while word five is offered.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    bus.load_valid = 1'b1;
    bus.load_data  = $urandom;
    check("w5_ready", 64'(bus.load_ready), 64'(1));
    @(negedge clk);
    #1;
    Reset_n = 1'b0;
    #1;
    check_reset_values("w5");
    check("w5_pending", 64'(exp_addr.size()), 64'(0));
    bus.load_valid = 1'b0;
    repeat (2) tick();
    Reset_n = 1'b1;
    repeat (3) tick();
    check("w5_writes", 64'(wr_seen), 64'(4));
    check("w5_count", 64'(word_count), 64'(0));
    check("w5_cpu_load", 64'(cpu_load), 64'(1));

    // Checksum of two complementary halves.
    do_reset();
    step(1'b1, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check("csum_pair", 64'(checksum), 64'(32'hFFFF_FFFF));
`else
    check("csum_pair", 64'(checksum), 64'(0));
`endif

    // Randomized sessions with gaps, early starts and occasional aborts.
    for (int r = 0; r < 10; r++) begin
      int n;
      do_reset();
      n = $urandom_range(36, 1);
      for (int i = 0; i < n; i++) begin
        if (!m_loading) break;
        step(($urandom % 4) != 0, $urandom, (i == n - 1) && ($urandom % 2 == 1),
             ($urandom % 8) == 0, ($urandom % 40) == 0);
      end
      if (m_loading && m_count > 0)
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      if (!m_loading) begin
        wait_run("rand_hold_len");
        step(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
        check("rand_running", 64'(running), 64'(1));
      end
      tick();
      check("rand_drained", 64'(exp_addr.size()), 64'(0));
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DEPTH, 32, instruction memory depth in words (power of two, 2..1024).
REQ-002 SHALL have parameter ADDR_W, 5, imem address width, equal to log2(DEPTH).
REQ-003 SHALL have parameter RST_CYCLES, 2, number of cycles cpu_reset is held before run (at least 1).
REQ-004 SHALL have a single clock and an asynchronous, active-low reset, with ports as follows:
  clk  in  1  rising-edge clock.
  Reset_n  in  1  asynchronous active-low reset.
  load_valid  in  1  host presents an instruction word.
  load_data  in  32  instruction word.
  load_last  in  1  qualifies load_data as the final word.
  load_ready  out  1  loader can accept a word this cycle.
  start  in  1  request run of the loaded program.
  abort  in  1  stop the CPU and return to IDLE.
  imem_we  out  1  instruction memory write strobe.
  imem_addr  out  ADDR_W  write address.
  imem_wdata  out  32  write data.
  cpu_reset  out  1  active-high reset to the CPU core.
  cpu_load  out  1  drives the CPU LoadInstructions input.
  running  out  1  CPU released and executing.
  word_count  out  ADDR_W+1  words written since the last clear.
  overflow  out  1  sticky flag: a word was offered while memory was full.
  checksum  out  32  XOR of all accepted words (see REQ-020).

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, HOLD, RUN.
REQ-006 SHALL drive load_ready=1 only in IDLE/LOAD while word_count<DEPTH; a transfer is load_valid&load_ready.
REQ-007 On a transfer, SHALL assert imem_we the next cycle, for exactly one cycle, with imem_addr=word_count (pre-increment) and imem_wdata=load_data; word_count SHALL increment in the same cycle that imem_we is asserted.
REQ-008 A transfer in IDLE SHALL move the FSM to LOAD; a transfer with load_last=1 SHALL move the FSM to HOLD in the cycle after the transfer (together with the write).
REQ-009 start in IDLE/LOAD with word_count>0 and no transfer in the same cycle SHALL move the FSM to HOLD; start with word_count==0 SHALL be ignored; a transfer in the same cycle as start SHALL take priority and start SHALL be ignored.
REQ-010 In LOAD with word_count==DEPTH, load_valid=1 SHALL set overflow; no write SHALL occur and imem_addr SHALL NOT wrap.
REQ-011 cpu_load SHALL be 1 in IDLE/LOAD and 0 otherwise; cpu_reset SHALL be 1 in IDLE/LOAD/HOLD and 0 in RUN.
REQ-012 HOLD SHALL last exactly RST_CYCLES cycles and then enter RUN; running SHALL be 1 only in RUN.
REQ-013 abort in any state SHALL enter IDLE next cycle, clear word_count, overflow and checksum, and cancel any pending write; abort SHALL win over simultaneous start, transfer or HOLD expiry.
REQ-014 start and load_valid in RUN SHALL be ignored; overflow SHALL NOT be set in RUN.
REQ-015 All outputs SHALL be registered, except load_ready, which SHALL be combinational from state and word_count.

Reset
REQ-016 Reset_n=0 SHALL immediately force: state IDLE, cpu_reset=1, cpu_load=0 until first clock then per REQ-011, imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, overflow=0, running=0, checksum=0.
REQ-017 Reset_n asserted mid-LOAD or mid-RUN SHALL discard the in-flight write; no imem_we pulse SHALL follow reset release.
REQ-018 Reset_n deassertion SHALL take effect on the next rising edge of clk; no state change SHALL occur on the deassertion edge itself.

Configuration
REQ-019 Macro PROGRAM_LOADER_CHECKSUM_EN SHALL control the checksum feature.
REQ-020 With PROGRAM_LOADER_CHECKSUM_EN defined, checksum SHALL XOR in each accepted word in the cycle its imem_we is asserted; without it, checksum SHALL be tied to 0 and no checksum register SHALL exist.

Verification
REQ-021 Load 11 words (first 0x200101A7), last flagged on the 11th -> imem addr 0..10 written in order, word_count=11, cpu_reset low exactly 2 cycles after the last write, running=1.
REQ-022 Offer 33 words with no load_last -> 32 writes, load_ready=0 after the 32nd, overflow=1, no write to addr 0 again; then start -> RUN.
REQ-023 start with word_count=0 -> remains IDLE, cpu_reset=1, running=0.
REQ-024 abort during RUN, together with start -> IDLE next cycle, cpu_reset=1, cpu_load=1, word_count=0.
REQ-025 Reset_n=0 on the transfer cycle of word 5 -> no imem_we pulse, all outputs at reset values, word_count=0.
REQ-026 With PROGRAM_LOADER_CHECKSUM_EN defined, load 0x0000FFFF then 0xFFFF0000 -> checksum=0xFFFFFFFF; without the macro, checksum=0.
